nes_pad_scheduler: RTL and testbench
====================================

NES_PAD_SCHEDULER -- requirements
Module: nes_pad_scheduler

Interface
REQ-001 Parameter: LATCH_TICKS, 600, latch high time in clocks (12 us at 50 MHz).
REQ-002 Parameter: HALF_TICKS, 300, pulse-low gap and pulse-high time in clocks; legal range 4..4095.
REQ-003 Parameter: POLL_DIV, 833333, clocks between automatic poll starts (60 Hz at 50 MHz).
REQ-004 Port: clock  in  1  system clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: force_poll  in  1  one-cycle request for an immediate poll.
REQ-007 Port: data0 / data1  in  1 each  serial data from pad 0 / pad 1, active-low, asynchronous.
REQ-008 Port: latch  out  1  latch line shared by both pads.
REQ-009 Port: pulse  out  1  clock line shared by both pads.
REQ-010 Port: pad0 / pad1  out  8 each  held button state {left,right,up,down,A,B,select,start}, 1 = pressed.
REQ-011 Port: press0 / press1  out  8 each  sticky newly-pressed mask, same bit order.
REQ-012 Port: valid  out  1  one-cycle strobe marking a pad0/pad1 update.
REQ-013 Port: ack  in  1  consumer acknowledge; clears press0/press1.
REQ-014 Port: busy  out  1  high while a poll is in progress (any state other than IDLE).

Function
REQ-015 All outputs SHALL be registered.
REQ-016 data0/data1 SHALL pass through 2-flop synchronizers before use; sampling SHALL use the synchronized value, inverted.
REQ-017 FSM states SHALL be IDLE, LATCH, GAP, CLK, DONE.
REQ-018 Poll timer SHALL count 0..POLL_DIV-1 continuously and raise a one-cycle tick at wrap; counting SHALL not pause during a poll.
REQ-019 IDLE SHALL go to LATCH on a timer tick, on force_poll, or when the pending flag is set.
REQ-020 A tick or force_poll arriving while busy SHALL set a single pending flag, not a queue; entering LATCH SHALL clear the flag.
REQ-021 LATCH SHALL drive latch=1 for exactly LATCH_TICKS cycles.
REQ-022 At LATCH exit, bit 0 (A) SHALL be sampled for both pads, then the FSM SHALL enter GAP.
REQ-023 GAP SHALL drive latch=0, pulse=0 for HALF_TICKS cycles, then enter CLK.
REQ-024 CLK SHALL drive pulse=1 for HALF_TICKS cycles, then sample the next bit.
REQ-025 Serial bit order SHALL be A, B, select, start, up, down, left, right.
REQ-026 After right is sampled (7th CLK exit), the FSM SHALL enter DONE; otherwise it SHALL return to GAP.
REQ-027 A 3-bit bit counter SHALL track 0..7 and SHALL not wrap mid-poll.
REQ-028 DONE SHALL last 1 cycle and perform these updates: pad0/pad1 <= captured values; valid=1; pressN <= (pressN & ~{8{ack}}) | (newN & ~padN_old); next state IDLE.
REQ-029 Outside DONE, ack=1 SHALL clear press0 and press1 on the next edge.
REQ-030 Because of the DONE update rule, ack in the DONE cycle SHALL clear old presses but keep the presses captured in that poll.
REQ-031 A poll SHALL occupy LATCH_TICKS + 14*HALF_TICKS + 1 cycles, from LATCH entry through DONE.

Reset
REQ-032 While reset=0: state=IDLE, counters=0, pending=0, latch=0, pulse=0, pad0=pad1=press0=press1=0, valid=0, busy=0, synchronizers=1 (released).
REQ-033 Reset asserted mid-poll SHALL abort within 1 cycle and drop latch/pulse to 0 with no valid strobe; the first poll after release SHALL start at the first timer tick or force_poll.

Structure
REQ-034 Package nes_pad_pkg SHALL hold the state enum, the bit-index constants (BIT_A..BIT_RIGHT mapped to output positions), and the default tick constants.
REQ-035 The design SHALL contain one sub-module, nes_pad_sync: a 2-flop synchronizer instantiated once per data line; everything else is in a single FSM/datapath.

Verification
REQ-036 With LATCH_TICKS=8, HALF_TICKS=4, force_poll, pad0 model pressing A only: latch high exactly 8 cycles; 7 pulses each 4 high / 4 low; valid at cycle 65; pad0=8'h08.
REQ-037 Pad1 pressing right+start, pad0 idle: pad1=8'h41, pad0=8'h00, press1=8'h41; second identical poll gives press1 still 8'h41 and no new bits.
REQ-038 press0=8'h08, then ack alone -> press0=8'h00 next cycle; ack in the DONE cycle with new up press -> press0=8'h20.
REQ-039 force_poll at cycle 10 of a poll plus a timer tick during the same poll -> exactly one extra poll starts 1 cycle after DONE.
REQ-040 reset=0 during the 3rd CLK phase -> latch=pulse=0 next cycle, no valid, pad0/pad1=0; POLL_DIV=200 -> next poll starts 200 cycles after release.

Source files
------------

// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the dual NES pad poll scheduler.
package nes_pad_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_GAP,
      S_CLK,
      S_DONE
   } state_t;

   // Output byte positions: {left,right,up,down,A,B,select,start}
   localparam int unsigned BIT_START  = 0;
   localparam int unsigned BIT_SELECT = 1;
   localparam int unsigned BIT_B      = 2;
   localparam int unsigned BIT_A      = 3;
   localparam int unsigned BIT_DOWN   = 4;
   localparam int unsigned BIT_UP     = 5;
   localparam int unsigned BIT_RIGHT  = 6;
   localparam int unsigned BIT_LEFT   = 7;

   localparam int unsigned DEF_LATCH_TICKS = 600;
   localparam int unsigned DEF_HALF_TICKS  = 300;
   localparam int unsigned DEF_POLL_DIV    = 833333;

   // Map serial shift index (A,B,select,start,up,down,left,right) to output position
   function automatic logic [2:0] serial_pos(input logic [2:0] idx);
      case (idx)
         3'd0:    return 3'(BIT_A);
         3'd1:    return 3'(BIT_B);
         3'd2:    return 3'(BIT_SELECT);
         3'd3:    return 3'(BIT_START);
         3'd4:    return 3'(BIT_UP);
         3'd5:    return 3'(BIT_DOWN);
         3'd6:    return 3'(BIT_LEFT);
         default: return 3'(BIT_RIGHT);
      endcase
   endfunction

endpackage

// File: rtl/nes_pad_scheduler_if.sv
// Pad scheduler bus: poll request, pad serial lines, held/pressed state and handshake.
interface nes_pad_scheduler_if;

   logic       force_poll;
   logic       data0;
   logic       data1;
   logic       latch;
   logic       pulse;
   logic [7:0] pad0;
   logic [7:0] pad1;
   logic [7:0] press0;
   logic [7:0] press1;
   logic       valid;
   logic       ack;
   logic       busy;

   modport master (
      output force_poll, data0, data1, ack,
      input  latch, pulse, pad0, pad1, press0, press1, valid, busy
   );

   modport slave (
      input  force_poll, data0, data1, ack,
      output latch, pulse, pad0, pad1, press0, press1, valid, busy
   );

endinterface

// File: rtl/nes_pad_sync.sv
// Two-flop synchronizer for one asynchronous pad data line; resets to the released level.
module nes_pad_sync (
   input  logic clock,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_meta <= 1'b1;
         r_q    <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/nes_pad_scheduler.sv
// Periodic/forced poll of two NES pads over a shared latch/pulse pair,
// with held button state, sticky newly-pressed masks and a valid strobe.
module nes_pad_scheduler
   import nes_pad_pkg::*;
#(
   parameter int unsigned LATCH_TICKS = DEF_LATCH_TICKS,
   parameter int unsigned HALF_TICKS  = DEF_HALF_TICKS,
   parameter int unsigned POLL_DIV    = DEF_POLL_DIV
) (
   input logic                clock,
   input logic                reset,
   nes_pad_scheduler_if.slave bus
);

   localparam int unsigned PH_MAX = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
   localparam int unsigned PW     = $clog2(PH_MAX + 1);
   localparam int unsigned DW     = $clog2(POLL_DIV);

   state_t         r_state;
   state_t         w_next;
   logic [PW-1:0]  r_ph;
   logic [DW-1:0]  r_div;
   logic [2:0]     r_bit;
   logic           r_pend;
   logic [7:0]     r_cap0;
   logic [7:0]     r_cap1;
   logic           r_latch;
   logic           r_pulse;
   logic           r_busy;
   logic           r_valid;
   logic [7:0]     r_pad0;
   logic [7:0]     r_pad1;
   logic [7:0]     r_press0;
   logic [7:0]     r_press1;
   logic           w_q0;
   logic           w_q1;
   logic           w_s0;
   logic           w_s1;
   logic           w_tick;
   logic           w_ph_end;
   logic           w_req;

   nes_pad_sync u_sync0 (.clock(clock), .reset(reset), .i_d(bus.data0), .o_q(w_q0));
   nes_pad_sync u_sync1 (.clock(clock), .reset(reset), .i_d(bus.data1), .o_q(w_q1));

   // Pad lines are active-low: a low level means the button is pressed
   assign w_s0     = ~w_q0;
   assign w_s1     = ~w_q1;
   assign w_tick   = (r_div == DW'(POLL_DIV - 1));
   assign w_req    = w_tick | bus.force_poll;
   assign w_ph_end = (r_state == S_LATCH) ? (r_ph == PW'(LATCH_TICKS - 1))
                                          : (r_ph == PW'(HALF_TICKS - 1));

   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin : next_state
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req || r_pend) w_next = S_LATCH;
         S_LATCH: if (w_ph_end) w_next = S_GAP;
         S_GAP:   if (w_ph_end) w_next = S_CLK;
         S_CLK:   if (w_ph_end) w_next = (r_bit == 3'd6) ? S_DONE : S_GAP;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Timer, phase timing, serial capture and result registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_div    <= '0;
         r_ph     <= '0;
         r_bit    <= '0;
         r_pend   <= 1'b0;
         r_cap0   <= '0;
         r_cap1   <= '0;
         r_latch  <= 1'b0;
         r_pulse  <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_pad0   <= '0;
         r_pad1   <= '0;
         r_press0 <= '0;
         r_press1 <= '0;
      end else begin
         r_div   <= w_tick ? '0 : r_div + DW'(1);
         r_ph    <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_ph + PW'(1);
         r_latch <= (w_next == S_LATCH);
         r_pulse <= (w_next == S_CLK);
         r_busy  <= (w_next != S_IDLE);
         r_valid <= (r_state == S_DONE);

         // One pending slot: requests during a poll collapse into a single rerun
         if (r_state == S_IDLE && w_next == S_LATCH) r_pend <= 1'b0;
         else if (r_state != S_IDLE && w_req)        r_pend <= 1'b1;

         if (r_state == S_LATCH && w_ph_end) begin
            r_bit                      <= 3'd0;
            r_cap0[serial_pos(3'd0)]   <= w_s0;
            r_cap1[serial_pos(3'd0)]   <= w_s1;
         end else if (r_state == S_CLK && w_ph_end) begin
            r_bit                           <= r_bit + 3'd1;
            r_cap0[serial_pos(r_bit + 3'd1)] <= w_s0;
            r_cap1[serial_pos(r_bit + 3'd1)] <= w_s1;
         end

         if (r_state == S_DONE) begin
            r_pad0   <= r_cap0;
            r_pad1   <= r_cap1;
            r_press0 <= (r_press0 & ~{8{bus.ack}}) | (r_cap0 & ~r_pad0);
            r_press1 <= (r_press1 & ~{8{bus.ack}}) | (r_cap1 & ~r_pad1);
         end else if (bus.ack) begin
            r_press0 <= '0;
            r_press1 <= '0;
         end
      end
   end

   assign bus.latch  = r_latch;
   assign bus.pulse  = r_pulse;
   assign bus.busy   = r_busy;
   assign bus.valid  = r_valid;
   assign bus.pad0   = r_pad0;
   assign bus.pad1   = r_pad1;
   assign bus.press0 = r_press0;
   assign bus.press1 = r_press1;

endmodule

// File: tb/tb_nes_pad_scheduler.sv
// Bench for nes_pad_scheduler: shift-register pad models on the latch/pulse lines,
// protocol timing measurement and a poll-level model of held/pressed state.
module tb_nes_pad_scheduler;

   localparam int unsigned LT = 8;
   localparam int unsigned HT = 4;
   localparam int unsigned PD = 200;
   localparam int POLL_LEN = LT + 14 * HT + 1;

   typedef struct {
      bit         ok;
      int         lat_hi;
      int         n_pulse;
      int         hi_min, hi_max, lo_min, lo_max;
      int         valid_at;
      int         valid_cnt;
      int         busy_cnt;
      logic [7:0] p0, p1, pr0, pr1;
   } poll_res_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic [7:0]  btn0 = '0;
   logic [7:0]  btn1 = '0;
   int          sidx = 0;
   int unsigned since_rel = 0;

   logic [7:0] exp_pad0 = '0, exp_pad1 = '0, exp_pr0 = '0, exp_pr1 = '0;

   nes_pad_scheduler_if bus ();

   nes_pad_scheduler #(
      .LATCH_TICKS(LT),
      .HALF_TICKS (HT),
      .POLL_DIV   (PD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) since_rel <= reset ? since_rel + 1 : 0;

   // Pad model: latch reloads at A, each pulse rise shifts to the next button
   always @(posedge bus.latch or posedge bus.pulse) begin
      if (bus.latch) sidx = 0;
      else           sidx = sidx + 1;
   end

   // Serial order A,B,select,start,up,down,left,right into byte {left,right,up,down,A,B,select,start}
   function automatic logic ser_bit(input logic [7:0] b, input int i);
      case (i)
         0: return b[3];
         1: return b[2];
         2: return b[1];
         3: return b[0];
         4: return b[5];
         5: return b[4];
         6: return b[7];
         7: return b[6];
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      bus.data0 = ~ser_bit(btn0, sidx);
      bus.data1 = ~ser_bit(btn1, sidx);
   end

   task automatic do_reset();
      btn0 = '0; btn1 = '0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      exp_pad0 = '0; exp_pad1 = '0; exp_pr0 = '0; exp_pr1 = '0;
   endtask

   // Wait until idle with enough room before the next automatic poll
   task automatic wait_safe(output bit ok);
      int guard;
      guard = 0;
      ok = 1'b1;
      @(negedge clock);
      while (bus.busy || (PD - (since_rel % PD)) < 80) begin
         @(negedge clock);
         guard++;
         if (guard > 1000) begin
            ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic run_poll(input logic [7:0] b0, input logic [7:0] b1, input bit ack_done,
                           output poll_res_t r);
      bit prev_p;
      int run;
      r = '{ok: 1'b0, lat_hi: 0, n_pulse: 0, hi_min: 1000000, hi_max: 0, lo_min: 1000000,
            lo_max: 0, valid_at: -1, valid_cnt: 0, busy_cnt: 0, p0: '0, p1: '0, pr0: '0, pr1: '0};
      wait_safe(r.ok);
      if (!r.ok) return;
      btn0 = b0; btn1 = b1;
      bus.force_poll = 1'b1;
      @(negedge clock);
      bus.force_poll = 1'b0;
      prev_p = 1'b0;
      run = 0;
      for (int c = 0; c < 150; c++) begin
         if (bus.latch) r.lat_hi++;
         if (bus.busy)  r.busy_cnt++;
         if (bus.valid) begin
            r.valid_cnt++;
            if (r.valid_at < 0) begin
               r.valid_at = c;
               r.p0 = bus.pad0; r.p1 = bus.pad1; r.pr0 = bus.press0; r.pr1 = bus.press1;
            end
         end
         if (!bus.latch && bus.busy) begin
            if (bus.pulse == prev_p) run++;
            else begin
               if (prev_p) begin
                  if (run < r.hi_min) r.hi_min = run;
                  if (run > r.hi_max) r.hi_max = run;
               end else begin
                  if (run < r.lo_min) r.lo_min = run;
                  if (run > r.lo_max) r.lo_max = run;
               end
               if (bus.pulse) r.n_pulse++;
               prev_p = bus.pulse;
               run = 1;
            end
         end
         // The cycle after the last pulse falls is the result-commit cycle
         bus.ack = ack_done && r.n_pulse == 7 && !bus.pulse && bus.busy && !bus.latch;
         if (r.valid_at >= 0 && c >= r.valid_at + 3) break;
         @(negedge clock);
      end
      bus.ack = 1'b0;
   endtask

   task automatic model_poll(input logic [7:0] b0, input logic [7:0] b1, input bit ack_done);
      exp_pr0  = (ack_done ? 8'h00 : exp_pr0) | (b0 & ~exp_pad0);
      exp_pr1  = (ack_done ? 8'h00 : exp_pr1) | (b1 & ~exp_pad1);
      exp_pad0 = b0;
      exp_pad1 = b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (bus.latch !== 1'b0 || bus.pulse !== 1'b0) begin bad++; $display("FAIL reset_lines got latch=%b pulse=%b want 0 0", bus.latch, bus.pulse); end
      total++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_flags got valid=%b busy=%b want 0 0", bus.valid, bus.busy); end
      total++; if ({bus.pad0, bus.pad1} !== 16'h0) begin bad++; $display("FAIL reset_pads got %h%h want 0000", bus.pad0, bus.pad1); end
      total++; if ({bus.press0, bus.press1} !== 16'h0) begin bad++; $display("FAIL reset_press got %h%h want 0000", bus.press0, bus.press1); end
      reset = 1'b1;
   endtask

   task automatic test_timing();
      poll_res_t r;
      do_reset();
      run_poll(8'h08, 8'h00, 1'b0, r);
      model_poll(8'h08, 8'h00, 1'b0);
      total++; if (r.lat_hi !== LT) begin bad++; $display("FAIL latch_width got=%0d want=%0d", r.lat_hi, LT); end
      total++; if (r.n_pulse !== 7) begin bad++; $display("FAIL pulse_count got=%0d want=7", r.n_pulse); end
      total++; if (r.hi_min !== HT || r.hi_max !== HT) begin bad++; $display("FAIL pulse_high got=%0d..%0d want=%0d", r.hi_min, r.hi_max, HT); end
      total++; if (r.lo_min !== HT || r.lo_max !== HT) begin bad++; $display("FAIL pulse_low got=%0d..%0d want=%0d", r.lo_min, r.lo_max, HT); end
      total++; if (r.valid_at !== POLL_LEN) begin bad++; $display("FAIL valid_cycle got=%0d want=%0d", r.valid_at, POLL_LEN); end
      total++; if (r.valid_cnt !== 1) begin bad++; $display("FAIL valid_width got=%0d want=1", r.valid_cnt); end
      total++; if (r.busy_cnt !== POLL_LEN) begin bad++; $display("FAIL busy_len got=%0d want=%0d", r.busy_cnt, POLL_LEN); end
      total++; if (r.p0 !== 8'h08 || r.p1 !== 8'h00) begin bad++; $display("FAIL a_only_pads got=%h/%h want=08/00", r.p0, r.p1); end
   endtask

   task automatic test_sticky();
      poll_res_t r;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         run_poll(8'h00, 8'h41, 1'b0, r);
         model_poll(8'h00, 8'h41, 1'b0);
         total++; if (r.p1 !== 8'h41 || r.p0 !== 8'h00) begin bad++; $display("FAIL sticky_pads%0d got=%h/%h want=00/41", k, r.p0, r.p1); end
         total++; if (r.pr1 !== 8'h41 || r.pr0 !== 8'h00) begin bad++; $display("FAIL sticky_press%0d got=%h/%h want=00/41", k, r.pr0, r.pr1); end
      end
   endtask

   task automatic test_ack();
      poll_res_t r;
      do_reset();
      run_poll(8'h08, 8'h00, 1'b0, r);
      model_poll(8'h08, 8'h00, 1'b0);
      total++; if (r.pr0 !== 8'h08) begin bad++; $display("FAIL ack_pre got=%h want=08", r.pr0); end
      bus.ack = 1'b1;
      @(negedge clock);
      bus.ack = 1'b0;
      exp_pr0 = '0; exp_pr1 = '0;
      total++; if (bus.press0 !== 8'h00) begin bad++; $display("FAIL ack_alone got=%h want=00", bus.press0); end
      run_poll(8'h00, 8'h00, 1'b0, r);
      model_poll(8'h00, 8'h00, 1'b0);
      run_poll(8'h08, 8'h00, 1'b0, r);
      model_poll(8'h08, 8'h00, 1'b0);
      run_poll(8'h28, 8'h00, 1'b1, r);
      model_poll(8'h28, 8'h00, 1'b1);
      total++; if (r.pr0 !== 8'h20 || r.p0 !== 8'h28) begin bad++; $display("FAIL ack_in_done got press=%h pad=%h want press=20 pad=28", r.pr0, r.p0); end
   endtask

   task automatic test_random();
      poll_res_t r;
      logic [7:0] b0, b1;
      bit ackd;
      for (int k = 0; k < 10; k++) begin
         b0   = 8'($urandom);
         b1   = 8'($urandom);
         ackd = 1'($urandom_range(0, 1));
         run_poll(b0, b1, ackd, r);
         model_poll(b0, b1, ackd);
         total++; if (r.p0 !== exp_pad0 || r.p1 !== exp_pad1) begin bad++; $display("FAIL rand_pads%0d got=%h/%h want=%h/%h", k, r.p0, r.p1, exp_pad0, exp_pad1); end
         total++; if (r.pr0 !== exp_pr0 || r.pr1 !== exp_pr1) begin bad++; $display("FAIL rand_press%0d got=%h/%h want=%h/%h", k, r.pr0, r.pr1, exp_pr0, exp_pr1); end
         total++; if (r.valid_at !== POLL_LEN) begin bad++; $display("FAIL rand_valid%0d got=%0d want=%0d", k, r.valid_at, POLL_LEN); end
         if ($urandom_range(0, 2) == 0) begin
            bus.ack = 1'b1;
            @(negedge clock);
            bus.ack = 1'b0;
            exp_pr0 = '0; exp_pr1 = '0;
            total++; if ({bus.press0, bus.press1} !== 16'h0) begin bad++; $display("FAIL rand_ack%0d got=%h%h want=0000", k, bus.press0, bus.press1); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int rises, second, valids, guard;
      bit prev_l;
      do_reset();
      guard = 0;
      while (since_rel != 150 && guard < 1000) begin @(negedge clock); guard++; end
      bus.force_poll = 1'b1;
      @(negedge clock);
      bus.force_poll = 1'b0;
      rises = 0; second = -1; valids = 0; prev_l = 1'b0;
      // A force at cycle 10 and the timer wrap near cycle 49 both land inside this poll
      for (int c = 0; c < 230; c++) begin
         if (bus.latch && !prev_l) begin
            rises++;
            if (rises == 2) second = c;
         end
         prev_l = bus.latch;
         if (bus.valid) valids++;
         bus.force_poll = (c == 10);
         @(negedge clock);
      end
      bus.force_poll = 1'b0;
      total++; if (rises !== 2) begin bad++; $display("FAIL pend_polls got=%0d want=2", rises); end
      total++; if (second !== POLL_LEN + 1) begin bad++; $display("FAIL pend_start got=%0d want=%0d", second, POLL_LEN + 1); end
      total++; if (valids !== 2) begin bad++; $display("FAIL pend_valids got=%0d want=2", valids); end
   endtask

   task automatic test_reset_mid();
      poll_res_t r;
      bit ok;
      int guard, vcount, n;
      do_reset();
      run_poll(8'hFF, 8'h81, 1'b0, r);
      total++; if (r.p0 !== 8'hFF || r.p1 !== 8'h81) begin bad++; $display("FAIL rmid_pre got=%h/%h want=ff/81", r.p0, r.p1); end
      wait_safe(ok);
      bus.force_poll = 1'b1;
      @(negedge clock);
      bus.force_poll = 1'b0;
      guard = 0;
      while (!(sidx == 3 && bus.pulse) && guard < 200) begin @(negedge clock); guard++; end
      total++; if (guard >= 200) begin bad++; $display("FAIL rmid_third_clk got timeout want pulse"); end
      reset = 1'b0;
      btn0 = '0; btn1 = '0;
      @(negedge clock);
      total++; if (bus.latch !== 1'b0 || bus.pulse !== 1'b0) begin bad++; $display("FAIL rmid_lines got latch=%b pulse=%b want 0 0", bus.latch, bus.pulse); end
      total++; if (bus.pad0 !== 8'h00 || bus.pad1 !== 8'h00) begin bad++; $display("FAIL rmid_pads got=%h/%h want=00/00", bus.pad0, bus.pad1); end
      vcount = 0;
      repeat (5) begin
         if (bus.valid) vcount++;
         @(negedge clock);
      end
      reset = 1'b1;
      n = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clock);
         #1;
         if (bus.valid) vcount++;
         if (bus.latch) begin n = k; break; end
      end
      total++; if (vcount !== 0) begin bad++; $display("FAIL rmid_valid got=%0d want=0", vcount); end
      total++; if (n !== PD) begin bad++; $display("FAIL rmid_restart got=%0d want=%0d", n, PD); end
   endtask

   initial begin
      bus.force_poll = 1'b0;
      bus.ack        = 1'b0;
      test_reset();
      test_timing();
      test_sticky();
      test_ack();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
